// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared definitions for the pipeline stages.
//   CW         : control word width
//   CTL_*      : control word bit indices (execute fields plus memory-stage fields)
//   ST_*       : status register bit indices {Z,N,V}
//   mem_state_e: memory handshake states
//   ex_mem_t   : execute -> memory datapath bundle (control word kept separate)
//   znv()      : status flags for a retiring SETF op
package pipeline_pkg;

    localparam int CW = 22;

    // memory-stage control fields
    localparam int CTL_WRITE  = 0;
    localparam int CTL_MREAD  = 1;
    localparam int CTL_MWRITE = 2;
    localparam int CTL_SETF   = 3;
    // execute-stage fields, carried through untouched
    localparam int CTL_SHIFT_LO = 4;
    localparam int CTL_SHIFT_HI = 5;
    localparam int CTL_ALUOP_LO = 6;
    localparam int CTL_ALUOP_HI = 7;
    localparam int CTL_LOADS    = 8;
    localparam int CTL_BSEL     = 9;
    localparam int CTL_ASEL     = 10;

    localparam int ST_Z = 2;
    localparam int ST_N = 1;
    localparam int ST_V = 0;

    typedef enum logic {IDLE, BUSY} mem_state_e;

    typedef struct packed {
        logic [15:0] data_rd;
        logic [15:0] result;
        logic        hb_rm;
        logic        hb_rn;
        logic [5:0]  inst_type;
    } ex_mem_t;

    // V uses the subtract overflow rule: operands differ in sign and the
    // result sign differs from the A operand.
    function automatic logic [2:0] znv(input logic [15:0] res,
                                       input logic        rn15,
                                       input logic        rm15);
        logic [2:0] f;
        f       = '0;
        f[ST_Z] = ~|res;
        f[ST_N] = res[15];
        f[ST_V] = (rn15 ^ rm15) & (rn15 ^ res[15]);
        return f;
    endfunction

endpackage

// File: rtl/pipeline_3_memory_mem_handshake_fsm.sv
// mem_handshake_fsm: req/ack sequencing for the memory stage.
//   clk, rst_n : clock, async active-low reset
//   memop      : registered op needs a memory transfer
//   mem_ack    : transfer completes this cycle
//   stall      : hold this stage and upstream
//   mem_err    : one-cycle pulse when the pending access is aborted
// The first un-acked cycle happens in IDLE, so with cnt reaching TIMEOUT
// the request has been stalled for exactly TIMEOUT cycles before abort.
module mem_handshake_fsm
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic memop,
    input  logic mem_ack,
    output logic stall,
    output logic mem_err
);

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    mem_state_e state, state_nx;
    logic [7:0] cnt, cnt_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        stall    = 1'b0;
        mem_err  = 1'b0;
        case (state)
            IDLE: begin
                if (memop && !mem_ack) begin
                    stall    = 1'b1;
                    state_nx = BUSY;
                    cnt_nx   = 8'd1;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt < TMO) begin
                    stall  = 1'b1;
                    cnt_nx = cnt + 8'd1;
                end else begin
                    // abort: let the op retire so writeback still happens
                    mem_err  = 1'b1;
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: rtl/pipeline_3_memory.sv
// pipeline_3_memory: memory stage. Registers execute outputs, runs the optional
// load/store over req/ack, stalls upstream while pending, owns ZNV status.
//   clk, rst                 : clock, async active-low reset
//   control_in .. inst_type_in: execute-stage outputs (captured when !stall)
//   control_out              : registered control, zeroed (bubble) while stalled
//   wb_data_out              : load data (0 on abort) or registered result
//   inst_type_out, status_out: registered inst type, {Z,N,V}
//   stall                    : hold upstream and this stage's input register
//   mem_req/we/addr/wdata    : request side; mem_rdata/mem_ack response side
//   mem_err                  : one-cycle abort pulse
module pipeline_3_memory
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CW      = 22
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] control_in,
    input  logic [15:0]   data_Rd_in,
    input  logic [15:0]   result_in,
    input  logic          highbit_shifted_Rm_in,
    input  logic          highbit_data_Rn_in,
    input  logic [5:0]    inst_type_in,
    output logic [CW-1:0] control_out,
    output logic [15:0]   wb_data_out,
    output logic [5:0]    inst_type_out,
    output logic [2:0]    status_out,
    output logic          stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [15:0]   mem_addr,
    output logic [15:0]   mem_wdata,
    input  logic [15:0]   mem_rdata,
    input  logic          mem_ack,
    output logic          mem_err
);

    logic [CW-1:0] ctrl_q;
    ex_mem_t       ex_q;
    logic [2:0]    status_q;
    logic          is_store, is_load, memop;

    // reset clears to a NOP, so mem_req/stall drop with rst asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q <= '0;
            ex_q   <= '0;
        end else if (!stall) begin
            ctrl_q <= control_in;
            ex_q   <= '{data_rd:   data_Rd_in,
                        result:    result_in,
                        hb_rm:     highbit_shifted_Rm_in,
                        hb_rn:     highbit_data_Rn_in,
                        inst_type: inst_type_in};
        end
    end

    // store wins if both memory bits are set
    assign is_store = ctrl_q[CTL_MWRITE];
    assign is_load  = ctrl_q[CTL_MREAD] & ~is_store;
    assign memop    = is_load | is_store;

    mem_handshake_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
        .clk     (clk),
        .rst_n   (rst),
        .memop   (memop),
        .mem_ack (mem_ack),
        .stall   (stall),
        .mem_err (mem_err)
    );

    // an op retires on any edge without stall, including after an abort
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            status_q <= '0;
        else if (!stall && ctrl_q[CTL_SETF])
            status_q <= znv(ex_q.result, ex_q.hb_rn, ex_q.hb_rm);
    end

    assign control_out   = stall ? '0 : ctrl_q;
    // ack low outside a completed transfer, so an aborted load yields 0
    assign wb_data_out   = is_load ? (mem_ack ? mem_rdata : 16'h0000) : ex_q.result;
    assign inst_type_out = ex_q.inst_type;
    assign status_out    = status_q;
    assign mem_req       = memop;
    assign mem_we        = is_store;
    assign mem_addr      = ex_q.result;
    assign mem_wdata     = ex_q.data_rd;

endmodule

// File: tb/tb_pipeline_3_memory.sv
module tb_pipeline_3_memory;

    localparam int TIMEOUT = 15;
    localparam logic [21:0] C_WR = 22'h1, C_RD = 22'h2, C_MW = 22'h4, C_SF = 22'h8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [21:0] control_in = '0;
    logic [15:0] data_Rd_in = '0, result_in = '0;
    logic        highbit_shifted_Rm_in = 1'b0, highbit_data_Rn_in = 1'b0;
    logic [5:0]  inst_type_in = '0;
    logic [21:0] control_out;
    logic [15:0] wb_data_out, mem_addr, mem_wdata;
    logic [5:0]  inst_type_out;
    logic [2:0]  status_out;
    logic        stall, mem_req, mem_we, mem_err;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int errors = 0;
    int checks = 0;

    pipeline_3_memory #(.TIMEOUT(TIMEOUT), .CW(22)) dut (
        .clk(clk), .rst(rst),
        .control_in(control_in), .data_Rd_in(data_Rd_in), .result_in(result_in),
        .highbit_shifted_Rm_in(highbit_shifted_Rm_in), .highbit_data_Rn_in(highbit_data_Rn_in),
        .inst_type_in(inst_type_in),
        .control_out(control_out), .wb_data_out(wb_data_out), .inst_type_out(inst_type_out),
        .status_out(status_out), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Holds the op currently in the stage and how many cycles it has waited
    // without an ack.
    logic [21:0] m_ctrl = '0;
    logic [15:0] m_rd = '0, m_res = '0;
    logic        m_rm = 1'b0, m_rn = 1'b0;
    logic [5:0]  m_it = '0;
    int          m_w = 0;
    logic [2:0]  m_st = '0;

    function automatic logic m_mem();  return m_ctrl[1] | m_ctrl[2]; endfunction
    function automatic logic m_load(); return m_ctrl[1] & ~m_ctrl[2]; endfunction
    function automatic logic e_stall(); return m_mem() && !mem_ack && (m_w < TIMEOUT); endfunction
    function automatic logic e_err();   return m_mem() && !mem_ack && (m_w >= TIMEOUT); endfunction
    function automatic logic [15:0] e_wb();
        if (!m_load()) return m_res;
        return mem_ack ? mem_rdata : 16'h0000;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ctrl <= '0; m_rd <= '0; m_res <= '0; m_rm <= 1'b0; m_rn <= 1'b0;
            m_it <= '0; m_w <= 0; m_st <= '0;
        end else if (e_stall()) begin
            m_w <= m_w + 1;
        end else begin
            if (m_ctrl[3])
                m_st <= {(m_res == 16'h0), m_res[15], (m_rn ^ m_rm) & (m_rn ^ m_res[15])};
            m_ctrl <= control_in; m_rd <= data_Rd_in; m_res <= result_in;
            m_rm <= highbit_shifted_Rm_in; m_rn <= highbit_data_Rn_in;
            m_it <= inst_type_in; m_w <= 0;
        end
    end

    always @(negedge clk) begin
        chk("stall",    32'(stall),         32'(e_stall()));
        chk("mem_err",  32'(mem_err),       32'(e_err()));
        chk("mem_req",  32'(mem_req),       32'(m_mem()));
        chk("mem_we",   32'(mem_we),        32'(m_ctrl[2]));
        chk("ctrl_out", 32'(control_out),   e_stall() ? 32'h0 : 32'(m_ctrl));
        chk("itype",    32'(inst_type_out), 32'(m_it));
        chk("status",   32'(status_out),    32'(m_st));
        if (m_mem()) begin
            chk("addr",  32'(mem_addr),  32'(m_res));
            chk("wdata", 32'(mem_wdata), 32'(m_rd));
        end
        if (!e_stall()) chk("wb_data", 32'(wb_data_out), 32'(e_wb()));
    end

    // ---------------- stimulus ----------------
    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [21:0] c, input logic [15:0] rd, input logic [15:0] res,
                          input logic rm, input logic rn, input logic [5:0] it);
        control_in = c; data_Rd_in = rd; result_in = res;
        highbit_shifted_Rm_in = rm; highbit_data_Rn_in = rn; inst_type_in = it;
    endtask

    initial begin
        int nst, nerr, errcyc;
        logic [15:0] wb_err;
        logic [21:0] ctl_err;

        #2;
        chk("rst_ctrl",   32'(control_out), 0);
        chk("rst_status", 32'(status_out),  0);
        chk("rst_req",    32'(mem_req),     0);
        chk("rst_stall",  32'(stall),       0);
        clk1(); rst = 1'b1;

        // ALU op, result 0, SETF
        set_in(C_WR | C_SF | 22'h40, 16'h1111, 16'h0000, 1'b0, 1'b0, 6'h01);
        clk1();
        set_in('0, '0, '0, 1'b0, 1'b0, '0);
        #1 chk("t1_ctrl", 32'(control_out), 'h49);
        chk("t1_stall", 32'(stall), 0);
        clk1();
        #1 chk("t1_status", 32'(status_out), 'b100);

        // non-SETF op leaves status alone
        set_in(C_WR, 16'h0, 16'h8000, 1'b1, 1'b0, 6'h02);
        clk1(); set_in('0, '0, '0, 1'b0, 1'b0, '0);
        clk1();
        #1 chk("nosetf_status", 32'(status_out), 'b100);

        // store, ack after 3 wait cycles; next op held during stall
        set_in(C_MW, 16'hBEEF, 16'h0040, 1'b0, 1'b0, 6'h03);
        clk1();
        set_in(C_WR, 16'h0, 16'h0007, 1'b0, 1'b0, 6'h04);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_stall", 32'(stall), 1);
            chk("st_req",   32'(mem_req), 1);
            chk("st_we",    32'(mem_we), 1);
            chk("st_addr",  32'(mem_addr), 'h0040);
            chk("st_wdata", 32'(mem_wdata), 'hBEEF);
            chk("st_ctrl",  32'(control_out), 0);
            clk1();
        end
        mem_ack = 1'b1;
        #1 chk("st_ack_stall", 32'(stall), 0);
        chk("st_ack_addr", 32'(mem_addr), 'h0040);
        clk1(); mem_ack = 1'b0;
        #1 chk("st_next_ctrl", 32'(control_out), 'h1);
        chk("st_next_wb", 32'(wb_data_out), 'h0007);
        set_in('0, '0, '0, 1'b0, 1'b0, '0);

        // zero-wait load then a load acked one cycle late
        set_in(C_RD | C_WR, 16'h0, 16'h0030, 1'b0, 1'b0, 6'h05);
        clk1();
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        set_in(C_RD | C_WR, 16'h0, 16'h0041, 1'b0, 1'b0, 6'h06);
        #1 chk("ld1_wb", 32'(wb_data_out), 'h1234);
        chk("ld1_stall", 32'(stall), 0);
        clk1();
        mem_ack = 1'b0; mem_rdata = 16'hDEAD;
        set_in('0, '0, '0, 1'b0, 1'b0, '0);
        #1 chk("ld2_stall", 32'(stall), 1);
        chk("ld2_addr", 32'(mem_addr), 'h0041);
        clk1();
        mem_ack = 1'b1; mem_rdata = 16'h5678;
        #1 chk("ld2_wb", 32'(wb_data_out), 'h5678);
        chk("ld2_stall_done", 32'(stall), 0);
        chk("ld2_ctrl", 32'(control_out), 'h3);
        clk1(); mem_ack = 1'b0;

        // MREAD and MWRITE both set: treated as a store
        set_in(C_RD | C_MW, 16'h00AA, 16'h0060, 1'b0, 1'b0, 6'h07);
        clk1();
        mem_ack = 1'b1; set_in('0, '0, '0, 1'b0, 1'b0, '0);
        #1 chk("both_we", 32'(mem_we), 1);
        chk("both_wb", 32'(wb_data_out), 'h0060);
        clk1(); mem_ack = 1'b0;

        // load never acked -> abort
        set_in(C_RD | C_WR, 16'h0, 16'h0050, 1'b0, 1'b0, 6'h08);
        clk1();
        set_in('0, '0, '0, 1'b0, 1'b0, '0);
        mem_rdata = 16'hFFFF;
        nst = 0; nerr = 0; errcyc = -1; wb_err = 16'hxxxx; ctl_err = '0;
        for (int c = 1; c <= 40; c++) begin
            #1;
            if (stall) nst++;
            if (mem_err) begin
                nerr++; errcyc = c; wb_err = wb_data_out; ctl_err = control_out;
            end
            clk1();
        end
        chk("tmo_stalls", 32'(nst), 15);
        chk("tmo_errs",   32'(nerr), 1);
        chk("tmo_cycle",  32'(errcyc), 16);
        chk("tmo_wb",     32'(wb_err), 0);
        chk("tmo_ctrl",   32'(ctl_err), 'h3);
        chk("tmo_idle",   32'(stall), 0);

        // SETF subtract overflow
        set_in(C_WR | C_SF, 16'h0, 16'h8000, 1'b1, 1'b0, 6'h09);
        clk1(); set_in('0, '0, '0, 1'b0, 1'b0, '0);
        clk1();
        #1 chk("sub_status", 32'(status_out), 'b011);

        // reset in the middle of a pending load
        set_in(C_RD | C_WR, 16'h0, 16'h0070, 1'b0, 1'b0, 6'h0A);
        clk1(); set_in('0, '0, '0, 1'b0, 1'b0, '0);
        clk1(); clk1();
        #1 chk("pre_rst_stall", 32'(stall), 1);
        #1 rst = 1'b0;
        #1 chk("rst_mid_req",   32'(mem_req), 0);
        chk("rst_mid_stall", 32'(stall), 0);
        chk("rst_mid_err",   32'(mem_err), 0);
        clk1(); clk1();
        rst = 1'b1;
        #1 chk("post_rst_ctrl",   32'(control_out), 0);
        chk("post_rst_wb",     32'(wb_data_out), 0);
        chk("post_rst_status", 32'(status_out), 0);
        chk("post_rst_req",    32'(mem_req), 0);
        clk1(); clk1();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_3_memory.md
Name: pipeline_3_memory

Overview:
- Third pipeline stage; consumes execute-stage outputs (control, Rd data, ALU result, operand high bits, inst type).
- Registers them, performs the optional data-memory load/store over a req/ack handshake, and stalls upstream while the access is pending.
- Maintains the ZNV status register, which execute no longer computes.
- Presents writeback data and control to the writeback stage.

Parameters:
- TIMEOUT, 15, max cycles a request may remain un-acked before being aborted (1..255).
- CW, 22, control word width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- control_in  input  CW  control word from execute
- data_Rd_in  input  16  store data (Rd value) from execute
- result_in  input  16  ALU result; memory address for ld/st
- highbit_shifted_Rm_in  input  1  bit 15 of ALU B operand
- highbit_data_Rn_in  input  1  bit 15 of ALU A operand
- inst_type_in  input  6  instruction class tag
- control_out  output  CW  registered control to writeback; forced to 0 (bubble) while stall=1
- wb_data_out  output  16  mem_rdata for loads, else registered result
- inst_type_out  output  6  registered inst type
- status_out  output  3  {Z,N,V} status register
- stall  output  1  upstream stages and this stage's input register must hold
- mem_req  output  1  memory request
- mem_we  output  1  1 = store, 0 = load
- mem_addr  output  16  registered result
- mem_wdata  output  16  registered Rd data
- mem_rdata  input  16  load data; valid in the ack cycle
- mem_ack  input  1  one transfer completes in each cycle with mem_req & mem_ack
- mem_err  output  1  one-cycle pulse when an access is aborted by timeout

Behaviour:
- Input register: captures all *_in inputs on the clk edge when stall=0; holds when stall=1.
  - Reset value: all zero, i.e. a NOP bubble.
- Control fields (package constants): CTL_WRITE=0 (register write), CTL_MREAD=1, CTL_MWRITE=2, CTL_SETF=3.
  - MREAD and MWRITE never both set; if both are set, MWRITE wins.
- Memory op: registered MREAD|MWRITE.
  - mem_req = memop & state allows.
  - mem_we = MWRITE.
  - mem_addr and mem_wdata are stable for the whole request.
- FSM states: IDLE, BUSY.
  - IDLE, memop, mem_ack=1: zero-wait transfer; stall=0; op retires at the next edge; stays IDLE.
  - IDLE, memop, mem_ack=0: stall=1; go to BUSY; cnt=1.
  - BUSY, mem_ack=1: stall=0; go to IDLE; cnt=0.
  - BUSY, mem_ack=0, cnt<TIMEOUT: stall=1; cnt++.
  - BUSY, mem_ack=0, cnt==TIMEOUT:
    - mem_err=1 and stall=0 in this cycle; go to IDLE.
    - A load returns wb_data_out=16'h0000; a store is dropped.
    - control_out passes through, so the writeback still occurs.
  - Non-memop: stall=0; mem_req=0; the FSM stays IDLE.
- Latency: a non-memory op is visible on the outputs in the cycle after capture (1 stage); a memory op stays until ack/timeout.
- Back-to-back memory ops: mem_req may stay high across the edge with a new address; each ack retires exactly one op.
- wb_data_out:
  - MREAD: mem_rdata in the ack cycle, 0 on timeout.
  - Otherwise: registered result.
- Status register (registered, reset 3'b000): updated at the edge where a CTL_SETF op retires (stall=0).
  - Z = ~|result.
  - N = result[15].
  - V = (Rn15 ^ Rm15) & (Rn15 ^ result[15]), the subtract overflow rule.
  - Ops without SETF leave status unchanged.
- Reset asserted mid-access:
  - Immediately forces mem_req=0, stall=0, mem_err=0 and state IDLE.
  - The pending op is discarded.

Decomposition:
- Shared package pipeline_pkg holds:
  - CW.
  - The CTL_* bit indices, with the existing execute fields asel=10, bsel=9, loads=8, ALUop=7:6, shift=5:4.
  - Status bit indices Z=2, N=1, V=0.
  - State enum {IDLE, BUSY}.
- One sub-module, mem_handshake_fsm: state, timeout counter, stall, mem_err.
- Registers and the status/datapath logic stay in the top module.

Test Plan:
- ALU op with result 16'h0000 and SETF -> no stall; control_out equals the registered control one cycle later; status_out=3'b100 after retire.
- Store: result 16'h0040, Rd 16'hBEEF, ack after 3 wait cycles -> mem_req=1, mem_we=1, addr 0x0040, wdata 0xBEEF held for 4 cycles; stall=1 for 3 cycles; control_out=0 during the stall.
- Load with zero-wait ack, mem_rdata=16'h1234, immediately followed by a load to 0x0041 acked 1 cycle later -> wb_data_out=0x1234 then the second value; no stall on the first; 1 stall cycle on the second.
- Load never acked, TIMEOUT=15 -> stall for 15 cycles; mem_err pulses once on cycle 16; wb_data_out=0; FSM returns to IDLE.
- SETF subtract with Rn15=0, Rm15=1, result=16'h8000 -> status_out=3'b011 (N, V).
- rst low during BUSY -> mem_req and stall drop asynchronously; after release, outputs are all zero and status_out=3'b000.
